// File: rtl/coax_pkg.sv
// Shared definitions for the coax receive path: word width, error codes from coax_rx
// and the coax_rx_buffer handshake state encoding.
package coax_pkg;

  localparam int unsigned DATA_W = 10;

  // One-hot error codes reported by coax_rx on rx_data while rx_error is high
  localparam logic [DATA_W-1:0] LOSS_OF_MID_BIT_TRANSITION = 10'h001;
  localparam logic [DATA_W-1:0] PARITY                     = 10'h002;
  localparam logic [DATA_W-1:0] INVALID_END_SEQUENCE       = 10'h004;
  localparam logic [DATA_W-1:0] OVERFLOW                   = 10'h008;

  typedef enum logic [2:0] {
    ST_WAIT        = 3'd0,
    ST_STROBE      = 3'd1,
    ST_RELEASE     = 3'd2,
    ST_ERR_CAPTURE = 3'd3,
    ST_RECOVER     = 3'd4
  } coax_state_e;

  // True when a code has exactly one bit set, i.e. looks like a valid coax_rx error code
  function automatic logic is_onehot_code(input logic [DATA_W-1:0] code);
    return (code != '0) && ((code & (code - DATA_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/coax_fifo.sv
// Generic synchronous first-word-fall-through FIFO. rd_data, empty, full and count are
// all registered; the head register is refreshed on every push/pop so no read mux escapes.
module coax_fifo #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CW'(1);
    end
  end

  // Next head: a write into an empty (or emptying) FIFO falls straight through
  always_comb begin
    head_next = rd_data;
    if ((count == CW'(0)) || (do_pop && (count == CW'(1)))) begin
      if (do_push) begin
        head_next = wr_data;
      end
    end else if (do_pop) begin
      head_next = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count   <= count_next;
      empty   <= (count_next == CW'(0));
      full    <= (count_next == CW'(DEPTH));
      rd_data <= head_next;
    end
  end

endmodule

// File: rtl/coax_rx_buffer.sv
// Acknowledges coax_rx words through its read-strobe handshake, queues them for the host and
// captures receiver errors. Optional statistics counters under COAX_RX_BUFFER_STATS_EN.
module coax_rx_buffer
  import coax_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_available,
  input  logic              rx_error,
  input  logic              rx_active,
  output logic              rx_read,
  output logic              rx_reset,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              error,
  output logic [DATA_W-1:0] error_code,
  input  logic              clear_error,
  output logic              busy
`ifdef COAX_RX_BUFFER_STATS_EN
  ,
  output logic [15:0]       word_total,
  output logic [7:0]        error_total
`endif
);

  coax_state_e state;
  logic        rst_pulse;
  logic        push_c;
  logic        capture_c;

  // A word is taken only from WAIT with space available and no error pending
  assign push_c    = (state == ST_WAIT) && !rx_error && rx_data_available && !full;
  assign capture_c = (state == ST_ERR_CAPTURE);
  assign rx_reset  = reset | rst_pulse;

  coax_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .wr_data (rx_data),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT;
      rx_read    <= 1'b0;
      rst_pulse  <= 1'b0;
      error      <= 1'b0;
      error_code <= '0;
      busy       <= 1'b0;
    end else begin
      busy      <= rx_active;
      rst_pulse <= 1'b0;
      if (clear_error) begin
        error      <= 1'b0;
        error_code <= '0;
      end
      case (state)
        ST_WAIT: begin
          if (rx_error) begin
            state <= ST_ERR_CAPTURE;
          end else if (rx_data_available && !full) begin
            rx_read <= 1'b1;
            state   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          rx_read <= 1'b0;
          state   <= rx_error ? ST_ERR_CAPTURE : ST_RELEASE;
        end
        ST_RELEASE: begin
          if (rx_error) begin
            state <= ST_ERR_CAPTURE;
          end else if (!rx_data_available) begin
            state <= ST_WAIT;
          end
        end
        // Capture overrides a simultaneous clear_error; the receiver is reset for one cycle
        ST_ERR_CAPTURE: begin
          error      <= 1'b1;
          error_code <= rx_data;
          rst_pulse  <= 1'b1;
          rx_read    <= 1'b0;
          state      <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (!rx_error && !rx_data_available) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          rx_read <= 1'b0;
          state   <= ST_WAIT;
        end
      endcase
    end
  end

`ifdef COAX_RX_BUFFER_STATS_EN
  // Saturating traffic counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      word_total  <= '0;
      error_total <= '0;
    end else begin
      if (push_c && (word_total != '1)) begin
        word_total <= word_total + 16'd1;
      end
      if (capture_c && (error_total != '1)) begin
        error_total <= error_total + 8'd1;
      end
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_c;
`endif

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Directed-plus-random bench for coax_rx_buffer: a queue model of the FIFO and an error-flag
// model are kept here and compared with the DUT through immediate assertions.
module tb_coax_rx_buffer;
  import coax_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_available;
  logic              rx_error;
  logic              rx_active;
  logic              rx_read;
  logic              rx_reset;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic              error;
  logic [DATA_W-1:0] error_code;
  logic              clear_error;
  logic              busy;
`ifdef COAX_RX_BUFFER_STATS_EN
  logic [15:0]       word_total;
  logic [7:0]        error_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model_q [$];
  int model_words = 0;
  int model_errs  = 0;

  always #5 clk = ~clk;

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_data_available (rx_data_available),
    .rx_error          (rx_error),
    .rx_active         (rx_active),
    .rx_read           (rx_read),
    .rx_reset          (rx_reset),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .empty             (empty),
    .full              (full),
    .count             (count),
    .error             (error),
    .error_code        (error_code),
    .clear_error       (clear_error),
    .busy              (busy)
`ifdef COAX_RX_BUFFER_STATS_EN
    ,
    .word_total        (word_total),
    .error_total       (error_total)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word as coax_rx would, optionally popping the head in the push cycle
  task automatic send_word(input logic [DATA_W-1:0] w, input int hold, input bit pop_too);
    int k;
    bit do_pop;
    do_pop = pop_too && (model_q.size() > 0);
    rx_data = w;
    rx_data_available = 1'b1;
    if (do_pop) begin
      check("pop_during_push_head", 16'(rd_data), 16'(model_q[0]));
      rd_en = 1'b1;
    end
    tick();
    if (do_pop) begin
      rd_en = 1'b0;
      void'(model_q.pop_front());
    end
    k = 0;
    while (rx_read !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("ack_seen", 16'(rx_read), 16'd1);
    model_q.push_back(w);
    model_words++;
    check("count_after_push", 16'(count), 16'(model_q.size()));
    tick();
    check("strobe_one_cycle", 16'(rx_read), 16'd0);
    repeat (hold) tick();
    rx_data_available = 1'b0;
    tick();
  endtask

  task automatic pop_word();
    check("pop_data", 16'(rd_data), 16'(model_q[0]));
    check("pop_not_empty", 16'(empty), 16'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(model_q.pop_front());
    check("pop_count", 16'(count), 16'(model_q.size()));
    check("pop_empty", 16'(empty), 16'(model_q.size() == 0));
  endtask

  // Receiver enters ERROR and holds it until it sees rx_reset
  task automatic raise_error(input logic [DATA_W-1:0] code, input bit clr_during);
    rx_error = 1'b1;
    rx_data = code;
    clear_error = clr_during;
    tick();
    tick();
    clear_error = 1'b0;
    model_errs++;
    check("err_flag", 16'(error), 16'd1);
    check("err_code", 16'(error_code), 16'(code));
    check("err_rx_reset_high", 16'(rx_reset), 16'd1);
    check("err_fifo_intact", 16'(count), 16'(model_q.size()));
    rx_error = 1'b0;
    tick();
    check("err_rx_reset_one_cycle", 16'(rx_reset), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w5;
    reset = 1'b1;
    rx_data = '0;
    rx_data_available = 1'b0;
    rx_error = 1'b0;
    rx_active = 1'b0;
    rd_en = 1'b0;
    clear_error = 1'b0;
    tick();
    tick();
    check("rst_rx_read", 16'(rx_read), 16'd0);
    check("rst_rx_reset", 16'(rx_reset), 16'd1);
    check("rst_error", 16'(error), 16'd0);
    check("rst_error_code", 16'(error_code), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full", 16'(full), 16'd0);
    check("rst_count", 16'(count), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    reset = 1'b0;
    tick();
    check("rx_reset_released", 16'(rx_reset), 16'd0);

    rx_active = 1'b1;
    tick();
    check("busy_follow_1", 16'(busy), 16'd1);
    rx_active = 1'b0;
    tick();
    check("busy_follow_0", 16'(busy), 16'd0);

    // Single word
    send_word(10'h2A5, 2, 1'b0);
    check("single_rd_data", 16'(rd_data), 16'h2A5);
    check("single_count", 16'(count), 16'd1);
    check("single_empty", 16'(empty), 16'd0);
    pop_word();

    // Burst of 5 with pops overlapping two of the pushes
    for (int i = 0; i < 5; i++) begin
      send_word(DATA_W'($urandom_range(0, 1023)), $urandom_range(0, 2), (i == 2) || (i == 4));
    end
    while (model_q.size() > 0) pop_word();

    // Fill to DEPTH, then a fifth word must wait for space
    for (int i = 0; i < DEPTH; i++) begin
      send_word(DATA_W'($urandom_range(0, 1023)), $urandom_range(0, 1), 1'b0);
    end
    check("fill_full", 16'(full), 16'd1);
    check("fill_count", 16'(count), 16'(DEPTH));
    w5 = DATA_W'($urandom_range(0, 1023));
    rx_data = w5;
    rx_data_available = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_ack_when_full", 16'(rx_read), 16'd0);
    end
    pop_word();
    for (int k = 0; k < 2 && rx_read !== 1'b1; k++) tick();
    check("ack_after_pop", 16'(rx_read), 16'd1);
    model_q.push_back(w5);
    model_words++;
    check("refill_count", 16'(count), 16'(DEPTH));
    tick();
    check("refill_strobe_one_cycle", 16'(rx_read), 16'd0);
    rx_data_available = 1'b0;
    tick();

    // Error capture with FIFO full, then clear
    raise_error(PARITY, 1'b0);
    check("err_head_intact", 16'(rd_data), 16'(model_q[0]));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    check("clear_error_flag", 16'(error), 16'd0);
    check("clear_error_code", 16'(error_code), 16'd0);
    raise_error(LOSS_OF_MID_BIT_TRANSITION, 1'b1);
    raise_error(OVERFLOW, 1'b0);
    check("err_code_is_onehot", 16'(is_onehot_code(error_code)), 16'd1);
    while (model_q.size() > 0) pop_word();

    // Reset while the strobe is high
    rx_data = DATA_W'($urandom_range(0, 1023));
    rx_data_available = 1'b1;
    tick();
    check("mid_strobe_read", 16'(rx_read), 16'd1);
    reset = 1'b1;
    #1;
    check("reset_drives_rx_reset", 16'(rx_reset), 16'd1);
    tick();
    check("reset_rx_read", 16'(rx_read), 16'd0);
    check("reset_count", 16'(count), 16'd0);
    check("reset_empty", 16'(empty), 16'd1);
    check("reset_error", 16'(error), 16'd0);
    rx_data_available = 1'b0;
    reset = 1'b0;
    model_q.delete();
    model_words = 0;
    model_errs = 0;
    tick();

    // Three words then one error
    for (int i = 0; i < 3; i++) begin
      send_word(DATA_W'($urandom_range(0, 1023)), $urandom_range(0, 2), 1'b0);
    end
    raise_error(INVALID_END_SEQUENCE, 1'b0);
`ifdef COAX_RX_BUFFER_STATS_EN
    check("stats_word_total", 16'(word_total), 16'd3);
    check("stats_error_total", 16'(error_total), 16'd1);
`endif
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;

    // Random mix of pushes and pops against the queue model
    for (int i = 0; i < 24; i++) begin
      if ((model_q.size() < DEPTH) && (($urandom % 2) == 0 || model_q.size() == 0)) begin
        send_word(DATA_W'($urandom), $urandom_range(0, 2), ($urandom % 3) == 0);
      end else begin
        pop_word();
      end
    end
    while (model_q.size() > 0) pop_word();
`ifdef COAX_RX_BUFFER_STATS_EN
    check("stats_word_total_final", 16'(word_total), 16'(model_words));
    check("stats_error_total_final", 16'(error_total), 16'(model_errs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
